alu_control_unit: RTL and testbench



---
 rtl/alu_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// alu_control_unit
// Sequencing controller for the 8-bit arithmetic datapath. It loads the
// operands into Q and M, then steers control lines c0..c7 through one adder
// pass (add/sub), eight radix-2 Booth iterations (mul) or eight restoring
// iterations (div). The division quotient is accumulated here, one bit per
// D_TEST cycle, MSB first.
module alu_control_unit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic       i_cnt_done,
    input  logic       i_q0,
    input  logic       i_qm1,
    input  logic       i_a7,
    output logic [1:0] o_op_q,
    output logic       o_in_sel,
    output logic       o_dp_clr,
    output logic       o_c0,
    output logic       o_c1,
    output logic       o_c2,
    output logic       o_c3,
    output logic       o_c4,
    output logic       o_c5,
    output logic       o_c6,
    output logic       o_c7,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_quotient
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD_X  = 4'd1,
        S_LOAD_Y  = 4'd2,
        S_M_EVAL  = 4'd3,
        S_M_SHIFT = 4'd4,
        S_D_SHIFT = 4'd5,
        S_D_SUB   = 4'd6,
        S_D_TEST  = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [1:0] r_op_q;
    logic       r_last;
    logic [7:0] r_quotient;

    assign o_op_q     = r_op_q;
    assign o_quotient = r_quotient;

    // State register and captured operation code.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_op_q  <= 2'b00;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_IDLE && i_start) begin
                r_op_q <= i_op;
            end
        end
    end

    // Division bookkeeping: last-iteration flag and MSB-first quotient.
    // A negative trial difference (a7=1) means the subtract is undone and the
    // quotient bit is 0; otherwise the bit is 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last     <= 1'b0;
            r_quotient <= 8'h00;
        end else begin
            if (r_state == S_D_SHIFT) begin
                r_last <= i_cnt_done;
            end
            if (r_state == S_LOAD_X && r_op_q == OP_DIV) begin
                r_quotient <= 8'h00;
            end else if (r_state == S_D_TEST) begin
                r_quotient <= {r_quotient[6:0], ~i_a7};
            end
        end
    end

    // Next-state and control-line decode; M_EVAL, M_SHIFT and D_TEST also
    // look at the live datapath status.
    always_comb begin
        w_state_nx = r_state;
        o_in_sel   = 1'b0;
        o_dp_clr   = 1'b0;
        o_c0       = 1'b0;
        o_c1       = 1'b0;
        o_c2       = 1'b0;
        o_c3       = 1'b0;
        o_c4       = 1'b0;
        o_c5       = 1'b0;
        o_c6       = 1'b0;
        o_c7       = 1'b0;
        o_busy     = (r_state != S_IDLE);
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx = S_LOAD_X;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOAD_X: begin
                o_c0       = 1'b1;
                o_dp_clr   = 1'b1;
                w_state_nx = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                o_c1     = 1'b1;
                o_in_sel = 1'b1;
                case (r_op_q)
                    OP_ADD:  w_state_nx = S_DONE;
                    OP_SUB:  w_state_nx = S_DONE;
                    OP_MUL:  w_state_nx = S_M_EVAL;
                    default: w_state_nx = S_D_SHIFT;
                endcase
            end
            S_M_EVAL: begin
                case ({i_q0, i_qm1})
                    2'b01: begin
                        o_c2 = 1'b1;
                        o_c3 = 1'b0;
                    end
                    2'b10: begin
                        o_c2 = 1'b1;
                        o_c3 = 1'b1;
                    end
                    default: begin
                        o_c2 = 1'b0;
                        o_c3 = 1'b0;
                    end
                endcase
                w_state_nx = S_M_SHIFT;
            end
            S_M_SHIFT: begin
                o_c4 = 1'b1;
                o_c5 = 1'b1;
                o_c6 = i_a7;
                if (i_cnt_done) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_M_EVAL;
                end
            end
            S_D_SHIFT: begin
                o_c4       = 1'b1;
                o_c5       = 1'b1;
                o_c6       = 1'b0;
                w_state_nx = S_D_SUB;
            end
            S_D_SUB: begin
                o_c2       = 1'b1;
                o_c3       = 1'b1;
                w_state_nx = S_D_TEST;
            end
            S_D_TEST: begin
                if (i_a7) begin
                    o_c2 = 1'b1;
                    o_c3 = 1'b0;
                end else begin
                    o_c2 = 1'b0;
                    o_c3 = 1'b0;
                end
                if (r_last) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_D_SHIFT;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                o_c7       = r_op_q[1];
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit
// Directed bench: a behavioural 8-bit datapath (A with a guard bit, Q, M,
// Q[-1], 3-bit counter) obeys the controller's c-lines so results on z and
// quotient can be compared against hand-computed values.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_i = 2'b00;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;

    logic       cnt_done, q0, qm1, a7;
    logic [1:0] op_q;
    logic       in_sel, dp_clr, c0, c1, c2, c3, c4, c5, c6, c7, busy, done;
    logic [7:0] quotient;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op_i),
        .i_cnt_done(cnt_done), .i_q0(q0), .i_qm1(qm1), .i_a7(a7),
        .o_op_q(op_q), .o_in_sel(in_sel), .o_dp_clr(dp_clr),
        .o_c0(c0), .o_c1(c1), .o_c2(c2), .o_c3(c3), .o_c4(c4), .o_c5(c5),
        .o_c6(c6), .o_c7(c7), .o_busy(busy), .o_done(done),
        .o_quotient(quotient)
    );

    // ---------------- datapath model ----------------
    // A carries a guard bit so the Booth step on 0x80 x 0x80 keeps its sign.
    logic [8:0]  a_r = 9'h000;
    logic [7:0]  q_r = 8'h00;
    logic [7:0]  m_r = 8'h00;
    logic        qm1_r = 1'b0;
    logic [2:0]  cnt_r = 3'd0;
    logic [7:0]  in_s;
    logic [8:0]  sum_s;
    logic [15:0] z_s;

    assign in_s     = in_sel ? y : x;
    assign sum_s    = c3 ? (a_r - {m_r[7], m_r}) : (a_r + {m_r[7], m_r});
    assign cnt_done = (cnt_r == 3'd7);
    assign q0       = q_r[0];
    assign qm1      = qm1_r;
    assign a7       = a_r[8];
    assign z_s      = c7 ? {a_r[7:0], q_r}
                    : (op_q[0] ? ({{8{q_r[7]}}, q_r} - {{8{m_r[7]}}, m_r})
                               : ({{8{q_r[7]}}, q_r} + {{8{m_r[7]}}, m_r}));

    // Datapath registers respond to the control lines.
    always @(posedge clk) begin
        if (dp_clr) begin
            a_r   <= 9'h000;
            qm1_r <= 1'b0;
            cnt_r <= 3'd0;
        end
        if (c0) q_r <= in_s;
        if (c1) m_r <= in_s;
        if (c2) a_r <= sum_s;
        if (c4) begin
            if (op_q == 2'b11) begin
                a_r <= {a_r[7:0], q_r[7]};
                q_r <= {q_r[6:0], c6};
            end else begin
                a_r   <= {c6, a_r[8:1]};
                q_r   <= {a_r[0], q_r[7:1]};
                qm1_r <= q_r[0];
            end
        end
        if (c5) cnt_r <= cnt_r + 3'd1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] all_outs();
        return {op_q, in_sel, dp_clr, c0, c1, c2, c3, c4, c5, c6, c7, busy, done, quotient};
    endfunction

    // Launch one operation, start sampled at cycle 0; observe up to DONE.
    task automatic run_op(input logic [1:0] opv, input logic [7:0] xv, input logic [7:0] yv,
                          output int done_cyc, output logic [15:0] z_d, output logic [7:0] q_d,
                          output int n_shift, output int n_c7);
        @(negedge clk);
        x = xv; y = yv; op_i = opv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1; n_shift = 0; n_c7 = 0; z_d = 16'h0000; q_d = 8'h00;
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (c4) n_shift++;
            if (c7) n_c7++;
            if (done) begin
                done_cyc = k;
                z_d = z_s;
                q_d = quotient;
            end
        end
        @(negedge clk);
        check_eq("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    int          dc, ns, n7;
    logic [15:0] zd;
    logic [7:0]  qd;
    int          n_done, op_bad, acc_cyc;

    initial begin
        // reset state
        #12;
        check_eq("reset_outs", {10'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add 25+17
        run_op(2'b00, 8'd25, 8'd17, dc, zd, qd, ns, n7);
        check_eq("add_cycle", dc, 32'd3);
        check_eq("add_z", {16'd0, zd}, 32'h002A);
        check_eq("add_c7", n7, 32'd0);

        // sub 10-20
        run_op(2'b01, 8'd10, 8'd20, dc, zd, qd, ns, n7);
        check_eq("sub_cycle", dc, 32'd3);
        check_eq("sub_z", {16'd0, zd}, 32'h0000FFF6);

        // mul 7 x -3
        run_op(2'b10, 8'h07, 8'hFD, dc, zd, qd, ns, n7);
        check_eq("mul_cycle", dc, 32'd19);
        check_eq("mul_shifts", ns, 32'd8);
        check_eq("mul_c7", n7, 32'd1);
        check_eq("mul_z", {16'd0, zd}, 32'h0000FFEB);

        // mul -128 x -128
        run_op(2'b10, 8'h80, 8'h80, dc, zd, qd, ns, n7);
        check_eq("mul_min_z", {16'd0, zd}, 32'h00004000);

        // div 200 / 7
        run_op(2'b11, 8'd200, 8'd7, dc, zd, qd, ns, n7);
        check_eq("div_cycle", dc, 32'd27);
        check_eq("div_quot", {24'd0, qd}, 32'h1C);
        check_eq("div_rem", {24'd0, zd[15:8]}, 32'h04);

        // quotient holds across a non-division operation
        run_op(2'b00, 8'd1, 8'd2, dc, zd, qd, ns, n7);
        check_eq("quot_hold", {24'd0, quotient}, 32'h1C);

        // div 5 / 9
        run_op(2'b11, 8'd5, 8'd9, dc, zd, qd, ns, n7);
        check_eq("div_small_quot", {24'd0, qd}, 32'h00);
        check_eq("div_small_rem", {24'd0, zd[15:8]}, 32'h05);

        // start held high with changing op during a mul
        @(negedge clk);
        op_i = 2'b10; start = 1'b1;
        @(posedge clk);
        n_done = 0; op_bad = 0; dc = -1;
        for (int k = 1; k <= 19; k++) begin
            #1 op_i = (k == 19) ? 2'b00 : k[1:0];
            @(negedge clk);
            if (op_q !== 2'b10) op_bad++;
            if (done) begin
                n_done++;
                dc = k;
            end
            @(posedge clk);
        end
        check_eq("spam_op_q", op_bad, 32'd0);
        check_eq("spam_done_cnt", n_done, 32'd1);
        check_eq("spam_done_cyc", dc, 32'd19);
        @(negedge clk);                       // cycle 20: IDLE, start sampled
        check_eq("spam_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);                       // cycle 21: new add accepted
        start = 1'b0;
        check_eq("spam_reaccept", {29'd0, busy, op_q}, 32'h4);
        acc_cyc = 0;
        while (!done && acc_cyc < 10) begin
            @(negedge clk);
            acc_cyc++;
        end
        check_eq("spam_add_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // reset at cycle 10 of a division (255 / 1)
        @(negedge clk);
        x = 8'd255; y = 8'd1; op_i = 2'b11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        check_eq("pre_rst_quot", {24'd0, quotient}, 32'h03);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outs", {10'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b00, 8'd3, 8'd4, dc, zd, qd, ns, n7);
        check_eq("post_rst_add_cycle", dc, 32'd3);
        check_eq("post_rst_add_z", {16'd0, zd}, 32'h0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
